// File: rtl/superh16_ifill_responder.sv
// superh16_ifill_responder
// L2-side responder for L1 instruction-cache line fills. Requests are merged
// against the in-flight line and the pending queue, queued when there is room,
// and otherwise dropped (counted). One line at a time is fetched from memory as
// BEAT_BITS-wide beats, assembled, and returned with a single-cycle l2_ack.
// Optional build macro SUPERH16_IFILL_PARITY_EN adds per-beat even parity
// checking (mem_rsp_par input, fill_err output) with one refetch on error.
module superh16_ifill_responder #(
   parameter int ADDR_WIDTH  = 48,
   parameter int LINE_BITS   = 512,
   parameter int BEAT_BITS   = 128,
   parameter int QUEUE_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  l2_req,
   input  logic [ADDR_WIDTH-1:0] l2_addr,
   output logic                  l2_ack,
   output logic [LINE_BITS-1:0]  l2_data,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_rsp_valid,
   input  logic [BEAT_BITS-1:0]  mem_rsp_data,
   output logic                  busy,
   output logic [7:0]            drop_cnt
`ifdef SUPERH16_IFILL_PARITY_EN
   ,
   input  logic                  mem_rsp_par,
   output logic                  fill_err
`endif
);

   localparam int BEATS = LINE_BITS / BEAT_BITS;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(QUEUE_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      COLLECT = 2'd2,
      RESPOND = 2'd3
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       beat_cnt;
   logic [LINE_BITS-1:0]   line_buf;
   logic [ADDR_WIDTH-1:0]  inflight_addr;
   logic                   inflight_vld;

   // Pending-request queue: per-entry valid bits make the merge search and
   // the empty/full tests independent of pointer arithmetic.
   logic [ADDR_WIDTH-1:0]  q_addr [QUEUE_DEPTH];
   logic [QUEUE_DEPTH-1:0] q_vld;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;

   logic                   q_empty;
   logic                   q_full;
   logic [ADDR_WIDTH-1:0]  q_head;
   logic [ADDR_WIDTH-1:0]  req_line;
   logic                   q_hit;
   logic                   merge;
   logic                   push;
   logic                   drop;
   logic                   pop;
   logic                   last_beat;
   logic                   fill_ok;
   logic                   fill_fail;
   logic [LINE_BITS-1:0]   line_fill;

`ifdef SUPERH16_IFILL_PARITY_EN
   logic                   beat_bad;
   logic                   line_bad;
   logic                   line_bad_now;
   logic                   retried;
   logic                   fill_retry;
`endif

   // Byte-offset bits of the request address carry no information here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^l2_addr[5:0];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_MAX) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign q_empty = ~|q_vld;
   assign q_full  = &q_vld;
   assign q_head  = q_addr[rd_ptr];
   assign busy    = (state != IDLE) || !q_empty;

   // Intake decision, fill completion decode, and line assembly
   always_comb begin
      req_line = {l2_addr[ADDR_WIDTH-1:6], 6'd0};
      q_hit    = 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         if (q_vld[i] && (q_addr[i] == req_line)) begin
            q_hit = 1'b1;
         end
      end
      // In RESPOND the in-flight register still holds the completed line,
      // so a re-request arriving with the ack merges into it.
      merge = l2_req && ((inflight_vld && (inflight_addr == req_line)) || q_hit);
      push  = l2_req && !merge && !q_full;
      drop  = l2_req && !merge && q_full;

      last_beat = (state == COLLECT) && mem_rsp_valid && (beat_cnt == LAST_BEAT);
`ifdef SUPERH16_IFILL_PARITY_EN
      beat_bad     = (mem_rsp_par != ^mem_rsp_data);
      line_bad_now = line_bad | beat_bad;
      fill_ok      = last_beat && !line_bad_now;
      fill_retry   = last_beat && line_bad_now && !retried;
      fill_fail    = last_beat && line_bad_now && retried;
`else
      fill_ok   = last_beat;
      fill_fail = 1'b0;
`endif
      pop = !q_empty && ((state == IDLE) || (state == RESPOND) || fill_fail);

      line_fill = line_buf;
      line_fill[int'(beat_cnt) * BEAT_BITS +: BEAT_BITS] = mem_rsp_data;
   end

   // Queue storage and pointers; push and pop may occur in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_vld  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            q_addr[i] <= '0;
         end
      end else begin
         if (pop) begin
            q_vld[rd_ptr] <= 1'b0;
            rd_ptr        <= ptr_inc(rd_ptr);
         end
         if (push) begin
            q_vld[wr_ptr]  <= 1'b1;
            q_addr[wr_ptr] <= req_line;
            wr_ptr         <= ptr_inc(wr_ptr);
         end
      end
   end

   // Saturating count of requests turned away by a full queue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= 8'd0;
      end else if (drop) begin
         drop_cnt <= sat_inc8(drop_cnt);
      end
   end

   // Fill sequencer: issue, collect beats, respond; all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         l2_ack        <= 1'b0;
         l2_data       <= '0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         beat_cnt      <= '0;
         line_buf      <= '0;
         inflight_addr <= '0;
         inflight_vld  <= 1'b0;
`ifdef SUPERH16_IFILL_PARITY_EN
         line_bad      <= 1'b0;
         retried       <= 1'b0;
         fill_err      <= 1'b0;
`endif
      end else begin
         l2_ack <= 1'b0;
`ifdef SUPERH16_IFILL_PARITY_EN
         fill_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pop) begin
                  inflight_addr <= q_head;
                  inflight_vld  <= 1'b1;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= q_head;
                  state         <= ISSUE;
               end
            end

            ISSUE: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  beat_cnt      <= '0;
`ifdef SUPERH16_IFILL_PARITY_EN
                  line_bad      <= 1'b0;
`endif
                  state         <= COLLECT;
               end
            end

            COLLECT: begin
               if (mem_rsp_valid) begin
                  line_buf <= line_fill;
                  beat_cnt <= beat_cnt + 1'b1;
`ifdef SUPERH16_IFILL_PARITY_EN
                  line_bad <= line_bad_now;
`endif
                  if (fill_ok) begin
                     l2_ack  <= 1'b1;
                     l2_data <= line_fill;
`ifdef SUPERH16_IFILL_PARITY_EN
                     retried <= 1'b0;
`endif
                     state   <= RESPOND;
                  end
`ifdef SUPERH16_IFILL_PARITY_EN
                  else if (fill_retry) begin
                     // First bad fetch: refetch the same line once.
                     mem_req_valid <= 1'b1;
                     mem_req_addr  <= inflight_addr;
                     retried       <= 1'b1;
                     state         <= ISSUE;
                  end else if (fill_fail) begin
                     // Second bad fetch: discard and move on as after an ack.
                     fill_err <= 1'b1;
                     retried  <= 1'b0;
                     if (pop) begin
                        inflight_addr <= q_head;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= q_head;
                        state         <= ISSUE;
                     end else begin
                        inflight_vld <= 1'b0;
                        state        <= IDLE;
                     end
                  end
`endif
               end
            end

            RESPOND: begin
               if (pop) begin
                  inflight_addr <= q_head;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= q_head;
                  state         <= ISSUE;
               end else begin
                  inflight_vld <= 1'b0;
                  state        <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/superh16_ifill_responder.md
Name: superh16_ifill_responder

Overview:
- L2-side responder for the L1 instruction-cache miss interface.
- Accepts line-fill requests (l2_req/l2_addr), fetches the 64-byte line from the backing memory port as four 128-bit beats, assembles it, and returns it with a single-cycle l2_ack plus 512-bit l2_data.
- Sits between the I-cache and the L2/memory fabric; serves one line at a time with a small pending-request queue.

Parameters:
- ADDR_WIDTH, 48, request/memory byte-address width; equals the core virtual address width.
- LINE_BITS, 512, fill line width; fixed 64 bytes.
- BEAT_BITS, 128, memory response beat width; beats per line = LINE_BITS/BEAT_BITS = 4.
- QUEUE_DEPTH, 2, pending request FIFO entries; power of two, ≥1.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- l2_req  in  1  fill request, sampled every cycle
- l2_addr  in  ADDR_WIDTH  requested line address; bits [5:0] ignored
- l2_ack  out  1  one-cycle fill-complete pulse
- l2_data  out  LINE_BITS  filled line; valid in the l2_ack cycle
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  line-aligned address, low 6 bits zero
- mem_rsp_valid  in  1  response beat valid; no backpressure
- mem_rsp_data  in  BEAT_BITS  beat data; beat k → l2_data[128k+127:128k]
- busy  out  1  FSM not IDLE or queue non-empty
- drop_cnt  out  8  saturating count of dropped requests

Behaviour:
- Reset values (async): l2_ack=0, l2_data=0, mem_req_valid=0, mem_req_addr=0, busy=0, drop_cnt=0, FSM=IDLE, queue empty, beat counter=0.
- Line address = l2_addr with bits [5:0] cleared.
- Request intake, each cycle l2_req=1:
  - Merge (no enqueue) if the line address matches the in-flight line or any queued entry.
  - Otherwise enqueue if the queue is not full.
  - Otherwise drop and increment drop_cnt, saturating at 255.
  - The I-cache re-requests on a later miss; drops are legal.
- A request is enqueued even when it arrives in the same cycle another entry is dequeued.
- Arrival in the l2_ack cycle compares against the just-completed line: a match merges, so there is no second ack for it.
- FSM:
  - IDLE: queue non-empty → pop head into the in-flight register → ISSUE (pop registered; ISSUE begins the next cycle).
  - ISSUE: mem_req_valid=1 with mem_req_addr = in-flight line. Valid and address held stable until mem_req_ready. On valid&ready → COLLECT, beat counter=0.
  - COLLECT: each mem_rsp_valid writes mem_rsp_data to slot[beat counter] and increments the counter. When the 4th beat (counter=3) arrives → RESPOND.
  - RESPOND: l2_ack=1 for exactly one cycle, l2_data = assembled line. Next state is ISSUE if the queue is non-empty (pop in the same cycle), else IDLE.
- l2_data is registered and holds its value between acks.
- mem_rsp_valid outside COLLECT is ignored.
- Minimum latency: request cycle T (queue empty, IDLE) → mem_req_valid at T+2 → with ready at T+2 and beats on T+3..T+6 → l2_ack at T+7.
- One request is outstanding to memory at a time; beats return in order.
- Reset mid-fill discards the partial line, the queue, and the in-flight line. The memory side is reset concurrently, so no stale beats are expected.

Optional Feature:
- Macro: SUPERH16_IFILL_PARITY_EN.
- When defined, adds these ports:
  - mem_rsp_par  in  1: even parity over mem_rsp_data.
  - fill_err  out  1: one-cycle pulse, reset 0.
- Parity mismatch on any beat marks the line bad. After the 4th beat the FSM does not ack; it returns to ISSUE and refetches the same line once.
- A second bad fetch pulses fill_err for one cycle, discards the line with no l2_ack, and proceeds as after RESPOND.
- When undefined, the ports are absent and no checking is performed.

Test Plan:
- Single fill: l2_req for 0x0000_1234_5678, ready=1, beats 0xA..,0xB..,0xC..,0xD.. → mem_req_addr=0x0000_1234_5640, l2_ack at T+7, l2_data[127:0]=beat0 … [511:384]=beat3.
- Backpressure: mem_req_ready low for 5 cycles → mem_req_valid and address stable throughout; ack delayed by exactly 5 cycles.
- Merge/queue: requests to 0x1000, 0x1010 (same line), 0x2000, 0x3000 on consecutive cycles → fills 0x1000, 0x2000, 0x3000 in order, three acks, drop_cnt=0.
- Overflow: 4 distinct lines on consecutive cycles while IDLE (QUEUE_DEPTH=2) → 3 acks, drop_cnt=1; 300 further drops → drop_cnt=255.
- Reset mid-COLLECT after 2 beats → all outputs at reset values; a new request completes normally with fresh data.
- Parity (macro on): bad parity on beat 2 once → two mem requests, one ack with correct data. Bad parity twice → fill_err pulse, no ack, busy=0 afterwards.
